mii_repeater_arbiter: RTL
=========================

// Module: mii_repeater_arbiter
// PURPOSE
//  Port-sharing controller for a multi-port MII repeater (hub). Watches the rx side of one
//  elastic buffer per port, picks the single active source, and drives the common repeat
//  bus back out to every other port. Detects collisions (two or more active ports) and
//  jams all ports. Sits between the per-port elastic buffers and the per-port tx muxes.
// PARAMETERS
//  PORTS      4   number of repeater ports (2..8)
//  JAM_MIN    8   minimum jam length, in nibbles (ce cycles), once a collision starts
//  CNT_WIDTH  16  width of the saturating collision and frame counters
// PORTS
//  clk        in   1          sole clock
//  rst        in   1          synchronous reset, active-high
//  ce         in   1          nibble strobe; same strobe drives every buffer's rx_ce
//  port_dv    in   PORTS      per-port rx_dv from the elastic buffers
//  port_er    in   PORTS      per-port rx_er from the elastic buffers
//  port_rxd   in   4*PORTS    per-port rxd; port n is bits [4n+3:4n]
//  tx_en      out  1          repeat-bus enable
//  tx_er      out  1          repeat-bus error
//  txd        out  4          repeat-bus data
//  tx_mask    out  PORTS      1 = port n transmits the repeat bus this nibble
//  col        out  1          collision/jam in progress
//  src        out  $clog2(PORTS)  index of the current source; valid in PASS only
//  col_count  out  CNT_WIDTH  collisions seen; saturates at all-ones
//  frame_count out CNT_WIDTH  clean frames repeated (PASS->IDLE, no jam); saturates
// BEHAVIOUR
//  - Reset: state IDLE. tx_en=0, tx_er=0, txd=0, tx_mask=0, col=0, src=0, both counters=0.
//    rst overrides ce. Reset mid-frame drops straight to IDLE with no trailing jam.
//  - Decisions and all output updates happen only on clocks with ce=1. Outputs are
//    registered: inputs sampled on a ce clock appear on the outputs 1 clock later and hold
//    until the next ce clock. With ce=0 every register, counters included, holds.
//  - n_act = popcount(port_dv), evaluated on the ce clock.
//  - IDLE: outputs idle (tx_en=0, tx_er=0, txd=0, tx_mask=0).
//    n_act==1 -> PASS: src := active index; repeat that port's nibble in the same update.
//    n_act>=2 -> JAM. n_act==0 -> stay in IDLE.
//  - PASS: tx_en=1, tx_er=port_er[src], txd=port_rxd[src], tx_mask = all ones except src.
//    port_dv[src]=0 and n_act==0 -> IDLE, frame_count++; outputs idle for that nibble.
//    port_dv[src]=0 with another port active -> JAM (collision).
//    Any port other than src active -> JAM, col_count++.
//    A buffer-underflow nibble (dv=1, er=1) on src is repeated unchanged as tx_er=1.
//    It does not count as a collision.
//  - JAM: tx_en=1, tx_er=0, txd=4'h5, tx_mask=all ones, col=1. Jam counter loads 0 on
//    entry and counts up each ce clock, saturating at JAM_MIN. col_count++ once on entry.
//    The increment is not repeated while in JAM.
//    Exit to IDLE only when n_act==0 AND counter>=JAM_MIN; outputs idle for that nibble.
//    If one port stays active after the others drop, keep jamming; no return to PASS.
//  - col=1 only in JAM. src holds its last value outside PASS.
//  - Counters saturate at 2^CNT_WIDTH-1 and never wrap.
//  - Simultaneous start: two ports raising dv on the same ce clock from IDLE goes straight
//    to JAM. Lowest-index priority is never used.
//  - The elastic buffers' own overflow/underflow flags are not inputs. Underflow reaches
//    this block only as the er-without-data pattern, which PASS forwards.
// TESTING
//  1. Single frame: port 2 dv for 20 ce nibbles, data 0..F.
//     -> tx_en=1 one clk after each ce; txd tracks port 2; tx_mask=4'b1011; frame_count=1.
//  2. Late collision: port 0 in PASS; port 3 raises dv at nibble 10 for 3 nibbles.
//     -> JAM next update, txd=5, tx_mask=4'b1111, col=1, col_count=1.
//     -> Jam lasts >=8 nibbles after entry, then IDLE.
//  3. Simultaneous start: ports 1 and 2 raise dv on the same ce.
//     -> JAM directly from IDLE; frame_count unchanged.
//  4. Long survivor: after a collision, port 1 stays active 30 nibbles.
//     -> jam persists all 30 nibbles, then IDLE; col_count increments once.
//  5. Underflow pass-through: source shows dv=1, er=1 for 1 nibble mid-frame.
//     -> tx_er=1 for that nibble only; no JAM; frame_count increments at end.
//  6. ce gating and reset: ce at 1/4 duty -> outputs change only 1 clk after ce.
//     Pulse rst mid-JAM -> next clk all outputs 0 and counters 0.
//     Saturation: preload col_count to max -> it holds at 16'hFFFF.

Source files
------------

// File: rtl/mii_repeater_arbiter.sv
// Repeater-hub port arbiter: selects one active rx source, repeats it to every other port,
// and jams all ports for at least JAM_MIN nibbles whenever two or more ports are active.
module mii_repeater_arbiter #(
  parameter int PORTS     = 4,
  parameter int JAM_MIN   = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic [PORTS-1:0]           port_dv,
  input  logic [PORTS-1:0]           port_er,
  input  logic [4*PORTS-1:0]         port_rxd,
  output logic                       tx_en,
  output logic                       tx_er,
  output logic [3:0]                 txd,
  output logic [PORTS-1:0]           tx_mask,
  output logic                       col,
  output logic [$clog2(PORTS)-1:0]   src,
  output logic [CNT_WIDTH-1:0]       col_count,
  output logic [CNT_WIDTH-1:0]       frame_count
);

  localparam int SRC_W  = $clog2(PORTS);
  localparam int JCNT_W = $clog2(JAM_MIN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, JAM = 2'd2} state_t;

  state_t              state_p0, state_d;
  logic [JCNT_W-1:0]   jcnt_p0, jcnt_d;
  logic [SRC_W-1:0]    src_d, act_idx;
  logic [3:0]          n_act;
  logic                col_inc, frm_inc;
  logic                en_nx, er_nx, col_nx;
  logic [3:0]          txd_nx;
  logic [PORTS-1:0]    mask_nx;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Active-port census; act_idx is meaningful only when exactly one port is active
  always_comb begin
    n_act   = 4'd0;
    act_idx = '0;
    for (int i = 0; i < PORTS; i++) begin
      n_act = n_act + {3'b000, port_dv[i]};
      if (port_dv[i]) act_idx = SRC_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      jcnt_p0  <= '0;
    end else if (ce) begin
      state_p0 <= state_d;
      jcnt_p0  <= jcnt_d;
    end
  end

  always_comb begin
    state_d = state_p0;
    jcnt_d  = jcnt_p0;
    src_d   = src;
    col_inc = 1'b0;
    frm_inc = 1'b0;
    case (state_p0)
      IDLE: begin
        if (n_act == 4'd1) begin
          state_d = PASS;
          src_d   = act_idx;
        end else if (n_act >= 4'd2) begin
          state_d = JAM;
          jcnt_d  = '0;
          col_inc = 1'b1;
        end
      end
      PASS: begin
        if (port_dv[src] && n_act == 4'd1) begin
          state_d = PASS;
        end else if (n_act == 4'd0) begin
          state_d = IDLE;
          frm_inc = 1'b1;
        end else begin
          state_d = JAM;
          jcnt_d  = '0;
          col_inc = 1'b1;
        end
      end
      JAM: begin
        // A lone survivor keeps the jam going; only total silence after JAM_MIN ends it
        if (n_act == 4'd0 && jcnt_p0 >= JCNT_W'(JAM_MIN)) begin
          state_d = IDLE;
        end else if (jcnt_p0 < JCNT_W'(JAM_MIN)) begin
          jcnt_d = jcnt_p0 + JCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the update being committed, derived from the state being entered
  always_comb begin
    en_nx   = 1'b0;
    er_nx   = 1'b0;
    col_nx  = 1'b0;
    txd_nx  = 4'h0;
    mask_nx = '0;
    case (state_d)
      PASS: begin
        en_nx   = 1'b1;
        er_nx   = port_er[src_d];
        txd_nx  = port_rxd[{src_d, 2'b00} +: 4];
        mask_nx = ~(PORTS'(1) << src_d);
      end
      JAM: begin
        en_nx   = 1'b1;
        txd_nx  = 4'h5;
        mask_nx = '1;
        col_nx  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en       <= 1'b0;
      tx_er       <= 1'b0;
      txd         <= 4'h0;
      tx_mask     <= '0;
      col         <= 1'b0;
      src         <= '0;
      col_count   <= '0;
      frame_count <= '0;
    end else if (ce) begin
      tx_en       <= en_nx;
      tx_er       <= er_nx;
      txd         <= txd_nx;
      tx_mask     <= mask_nx;
      col         <= col_nx;
      src         <= src_d;
      col_count   <= col_inc ? sat_inc(col_count) : col_count;
      frame_count <= frm_inc ? sat_inc(frame_count) : frame_count;
    end
  end

endmodule
